dma_fifo_device: RTL and testbench

- Next-generation memory-mapped DMA client peripheral on the 16-bit peripheral bus.
- Holds a parametrised-depth data FIFO between the CPU and the DMA controller, so multi-word bursts run without a per-word CPU handshake.
- Adds a transfer state machine, a remaining-word counter, sticky status flags and an interrupt output.

---
 rtl/dma_fifo_device.sv | 226 ++++++++++++++++++++++
 tb/tb_dma_fifo_device.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_device.sv
// dma_fifo_device: memory-mapped DMA client with a parametrised data FIFO,
// a two-state transfer FSM, a remaining-word counter, sticky status flags
// and a level interrupt.
module dma_fifo_device #(
    parameter logic [14:0] BASE_ADDR  = 15'h0100,
    parameter int unsigned DEC_WD     = 4,
    parameter int unsigned FIFO_AW    = 3,
    parameter logic        IRQ_EN_DEF = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq,
    output logic        dma_rqst,
    output logic        dma_rd_wr,
    output logic [15:0] dma_start_address,
    output logic [15:0] dma_num_words,
    output logic        dev_ack,
    output logic [15:0] dev_out,
    input  logic [15:0] dev_in,
    input  logic        dma_ack,
    input  logic        dma_end_flag,
    input  logic        dma_error_flag
);

    localparam int unsigned IW    = DEC_WD - 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [IW-1:0] R_START  = IW'(0);
    localparam logic [IW-1:0] R_NWORDS = IW'(1);
    localparam logic [IW-1:0] R_CONFIG = IW'(2);
    localparam logic [IW-1:0] R_STATUS = IW'(3);
    localparam logic [IW-1:0] R_DATA   = IW'(4);
    localparam logic [IW-1:0] R_LEVEL  = IW'(5);
    localparam logic [IW-1:0] R_REMAIN = IW'(6);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e              state_q, state_d;
    logic [FIFO_AW:0]    wptr_q, wptr_d;
    logic [FIFO_AW:0]    rptr_q, rptr_d;
    logic [15:0]         start_addr_q, start_addr_d;
    logic [15:0]         n_words_q, n_words_d;
    logic [15:0]         remain_q, remain_d;
    logic                rd_wr_q, rd_wr_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [15:0]         mem_q [DEPTH];

    logic                sel, wr, rd;
    logic [IW-1:0]       reg_idx;
    logic                wr_cfg, wr_status, wr_data, rd_data;
    logic                busy, empty, full;
    logic [FIFO_AW:0]    level;
    logic                xfer, dma_push, dma_pop, cpu_push, cpu_pop, push, pop;
    logic [15:0]         push_data;
    logic                ovf_set, unf_set;
    logic                start_req, start_go, start_zero, abort, flush;
    logic                err_evt, wr_done, done_evt;

    // Bus decode and FIFO/transfer qualifiers
    assign sel       = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign wr        = sel & (|per_we);
    assign rd        = sel & ~(|per_we);
    assign reg_idx   = per_addr[IW-1:0];
    assign wr_cfg    = wr & (reg_idx == R_CONFIG);
    assign wr_status = wr & (reg_idx == R_STATUS);
    assign wr_data   = wr & (reg_idx == R_DATA);
    assign rd_data   = rd & (reg_idx == R_DATA);

    assign busy  = (state_q == S_BUSY);
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q == {~rptr_q[FIFO_AW], rptr_q[FIFO_AW-1:0]});
    assign level = wptr_q - rptr_q;

    assign dma_rqst          = busy;
    assign dma_rd_wr         = rd_wr_q;
    assign dma_start_address = start_addr_q;
    assign dma_num_words     = n_words_q;
    assign dev_ack           = busy & (rd_wr_q ? ~full : ~empty);
    assign dev_out           = empty ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];
    assign irq               = irq_en_q & (done_q | err_q | ovf_q);

    assign xfer      = dma_rqst & dev_ack & dma_ack;
    assign dma_push  = xfer & rd_wr_q;
    assign dma_pop   = xfer & ~rd_wr_q;
    // The DMA side owns the write port if both sides ever collide
    assign cpu_push  = wr_data & ~full & ~dma_push;
    assign cpu_pop   = rd_data & ~empty;
    assign ovf_set   = wr_data & full;
    assign unf_set   = rd_data & empty;
    assign push      = dma_push | cpu_push;
    assign pop       = dma_pop | cpu_pop;
    assign push_data = dma_push ? dev_in : per_din;

    assign start_req  = wr_cfg & per_din[0] & ~busy;
    assign start_go   = start_req & (n_words_q != '0);
    assign start_zero = start_req & (n_words_q == '0);
    assign abort      = wr_cfg & per_din[1] & busy;
    assign flush      = start_go | (wr_cfg & per_din[4]);

    // Error outranks completion when both arrive together
    assign err_evt  = busy & (dma_error_flag | abort);
    assign wr_done  = busy & ~rd_wr_q & (remain_q == '0) & empty;
    assign done_evt = (busy & (dma_end_flag | wr_done) & ~err_evt) | start_zero;

    // Next-state computation for the FSM, registers, pointers and flags
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        start_addr_d = start_addr_q;
        n_words_d    = n_words_q;
        remain_d     = remain_q;
        rd_wr_d      = rd_wr_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;

        if (wr && reg_idx == R_START && !busy)  start_addr_d = per_din;
        if (wr && reg_idx == R_NWORDS && !busy) n_words_d    = per_din;
        if (wr_cfg) begin
            irq_en_d = per_din[3];
            if (!busy) rd_wr_d = per_din[2];
        end

        case (state_q)
            S_IDLE:  if (start_go) state_d = S_BUSY;
            S_BUSY:  if (err_evt || done_evt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (start_go)                       remain_d = n_words_q;
        else if (xfer && remain_q != '0)    remain_d = remain_q - 16'd1;

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
        end

        // Clear first, then set, so a same-cycle set event wins
        if (wr_status) begin
            if (per_din[1]) done_d = 1'b0;
            if (per_din[2]) err_d  = 1'b0;
            if (per_din[3]) ovf_d  = 1'b0;
            if (per_din[4]) unf_d  = 1'b0;
        end
        if (start_go) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (done_evt) done_d = 1'b1;
        if (err_evt)  err_d  = 1'b1;
        if (ovf_set)  ovf_d  = 1'b1;
        if (unf_set)  unf_d  = 1'b1;
    end

    // Control and status state, asynchronously reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            start_addr_q <= '0;
            n_words_q    <= '0;
            remain_q     <= '0;
            rd_wr_q      <= 1'b0;
            irq_en_q     <= IRQ_EN_DEF;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            start_addr_q <= start_addr_d;
            n_words_q    <= n_words_d;
            remain_q     <= remain_d;
            rd_wr_q      <= rd_wr_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // FIFO storage; contents need no reset since EMPTY masks dev_out
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q[FIFO_AW-1:0]] <= push_data;
    end

    // Combinational register read mux, zero when not selected
    always_comb begin
        per_dout = '0;
        if (rd) begin
            case (reg_idx)
                R_START:  per_dout = start_addr_q;
                R_NWORDS: per_dout = n_words_q;
                R_CONFIG: per_dout = {12'd0, irq_en_q, rd_wr_q, 2'b00};
                R_STATUS: per_dout = {9'd0, full, empty, unf_q, ovf_q, err_q, done_q, busy};
                R_DATA:   per_dout = dev_out;
                R_LEVEL:  per_dout = {{(15-FIFO_AW){1'b0}}, level};
                R_REMAIN: per_dout = remain_q;
                default:  per_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fifo_device.sv
// tb_dma_fifo_device: directed test of dma_fifo_device (depth-4 FIFO)
// with hand-computed expectations and immediate assertions.
module tb_dma_fifo_device;

    localparam logic [14:0] BASE = 15'h0100;

    localparam logic [3:0] O_START  = 4'h0;
    localparam logic [3:0] O_NWORDS = 4'h2;
    localparam logic [3:0] O_CONFIG = 4'h4;
    localparam logic [3:0] O_STATUS = 4'h6;
    localparam logic [3:0] O_DATA   = 4'h8;
    localparam logic [3:0] O_LEVEL  = 4'hA;
    localparam logic [3:0] O_REMAIN = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        irq;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error_flag;

    int checks = 0;
    int errors = 0;

    dma_fifo_device #(
        .BASE_ADDR (15'h0100),
        .DEC_WD    (4),
        .FIFO_AW   (2),
        .IRQ_EN_DEF(1'b0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .per_addr         (per_addr),
        .per_din          (per_din),
        .per_en           (per_en),
        .per_we           (per_we),
        .per_dout         (per_dout),
        .irq              (irq),
        .dma_rqst         (dma_rqst),
        .dma_rd_wr        (dma_rd_wr),
        .dma_start_address(dma_start_address),
        .dma_num_words    (dma_num_words),
        .dev_ack          (dev_ack),
        .dev_out          (dev_out),
        .dev_in           (dev_in),
        .dma_ack          (dma_ack),
        .dma_end_flag     (dma_end_flag),
        .dma_error_flag   (dma_error_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] waddr(input logic [3:0] off);
        logic [14:0] a;
        a = BASE | {11'd0, off};
        return a[14:1];
    endfunction

    // Called at posedge+1; returns at posedge+1
    task automatic bus_write(input logic [3:0] off, input logic [15:0] data);
        per_addr = waddr(off);
        per_din  = data;
        per_we   = 2'b11;
        per_en   = 1'b1;
        @(posedge clk);
        #1;
        per_en   = 1'b0;
        per_we   = 2'b00;
    endtask

    task automatic bus_read_check(input logic [3:0] off, input logic [15:0] exp, input string tag);
        per_addr = waddr(off);
        per_we   = 2'b00;
        per_en   = 1'b1;
        #2;
        check(tag, per_dout, exp);
        @(posedge clk);
        #1;
        per_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
        dev_in = '0; dma_ack = 1'b0; dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_dma_rqst", {15'd0, dma_rqst}, 16'd0);
        check("rst_dev_ack",  {15'd0, dev_ack},  16'd0);
        check("rst_irq",      {15'd0, irq},      16'd0);
        check("rst_dev_out",  dev_out,           16'd0);
        check("rst_per_dout", per_dout,          16'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1. Read burst of three words
        bus_write(O_START, 16'h0200);
        bus_write(O_NWORDS, 16'd3);
        bus_write(O_CONFIG, 16'h0005);
        check("t1_rqst", {15'd0, dma_rqst}, 16'd1);
        check("t1_rdwr", {15'd0, dma_rd_wr}, 16'd1);
        check("t1_saddr", dma_start_address, 16'h0200);
        check("t1_nwords", dma_num_words, 16'd3);
        dma_ack = 1'b1;
        dev_in = 16'hA001; @(posedge clk); #1;
        dev_in = 16'hA002; @(posedge clk); #1;
        dev_in = 16'hA003; @(posedge clk); #1;
        dma_ack = 1'b0;
        dma_end_flag = 1'b1; @(posedge clk); #1;
        dma_end_flag = 1'b0;
        check("t1_rqst_idle", {15'd0, dma_rqst}, 16'd0);
        bus_read_check(O_LEVEL,  16'd3,      "t1_level");
        bus_read_check(O_REMAIN, 16'd0,      "t1_remain");
        bus_read_check(O_STATUS, 16'h0002,   "t1_status_done");
        bus_read_check(O_DATA,   16'hA001,   "t1_data0");
        bus_read_check(O_DATA,   16'hA002,   "t1_data1");
        bus_read_check(O_DATA,   16'hA003,   "t1_data2");
        bus_read_check(O_DATA,   16'h0000,   "t1_data_empty");
        bus_read_check(O_STATUS, 16'h0032,   "t1_status_unf");
        bus_write(O_STATUS, 16'h001E);

        // 2. Backpressure with a depth-4 FIFO
        bus_write(O_NWORDS, 16'd6);
        bus_write(O_CONFIG, 16'h0005);
        dma_ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            dev_in = 16'hB000 + 16'(i);
            @(posedge clk); #1;
        end
        check("t2_ack_full", {15'd0, dev_ack}, 16'd0);
        dev_in = 16'hB005;
        bus_read_check(O_STATUS, 16'h0041, "t2_status_full");
        bus_read_check(O_REMAIN, 16'd2,    "t2_remain2");
        bus_read_check(O_DATA,   16'hB001, "t2_pop");
        check("t2_ack_after_pop", {15'd0, dev_ack}, 16'd1);
        @(posedge clk); #1;
        check("t2_ack_refull", {15'd0, dev_ack}, 16'd0);
        dma_ack = 1'b0;
        bus_read_check(O_REMAIN, 16'd1, "t2_remain1");
        bus_read_check(O_LEVEL,  16'd4, "t2_level4");
        bus_write(O_CONFIG, 16'h0002);
        bus_read_check(O_STATUS, 16'h0044, "t2_abort_err");
        bus_write(O_STATUS, 16'h001E);
        bus_write(O_CONFIG, 16'h0010);

        // 3. Write mode, completion without dma_end_flag
        bus_write(O_NWORDS, 16'd2);
        bus_write(O_CONFIG, 16'h0001);
        check("t3_ack_empty", {15'd0, dev_ack}, 16'd0);
        bus_write(O_DATA, 16'h1111);
        bus_write(O_DATA, 16'h2222);
        bus_read_check(O_LEVEL, 16'd2, "t3_level2");
        check("t3_dev_out0", dev_out, 16'h1111);
        check("t3_ack", {15'd0, dev_ack}, 16'd1);
        check("t3_rdwr", {15'd0, dma_rd_wr}, 16'd0);
        dma_ack = 1'b1;
        @(posedge clk); #1;
        check("t3_dev_out1", dev_out, 16'h2222);
        @(posedge clk); #1;
        check("t3_still_busy", {15'd0, dma_rqst}, 16'd1);
        @(posedge clk); #1;
        dma_ack = 1'b0;
        check("t3_idle", {15'd0, dma_rqst}, 16'd0);
        check("t3_dev_out_empty", dev_out, 16'h0000);
        bus_read_check(O_STATUS, 16'h0022, "t3_status_done");
        bus_read_check(O_REMAIN, 16'd0,    "t3_remain0");
        bus_write(O_STATUS, 16'h001E);

        // 4. End and error together, interrupt and clear
        bus_write(O_CONFIG, 16'h000D);
        check("t4_busy", {15'd0, dma_rqst}, 16'd1);
        check("t4_irq_pre", {15'd0, irq}, 16'd0);
        dma_end_flag = 1'b1; dma_error_flag = 1'b1;
        @(posedge clk); #1;
        dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        check("t4_rqst", {15'd0, dma_rqst}, 16'd0);
        check("t4_irq", {15'd0, irq}, 16'd1);
        bus_read_check(O_STATUS, 16'h0024, "t4_status_err");
        bus_write(O_STATUS, 16'h0004);
        check("t4_irq_clr", {15'd0, irq}, 16'd0);

        // 5. Overflow, then register lock while busy
        for (int i = 0; i < 5; i++) bus_write(O_DATA, 16'hC000 + 16'(i));
        bus_read_check(O_STATUS, 16'h0048, "t5_status_ovf");
        bus_read_check(O_LEVEL,  16'd4,    "t5_level_full");
        check("t5_irq_ovf", {15'd0, irq}, 16'd1);
        bus_write(O_CONFIG, 16'h0009);
        check("t5_busy", {15'd0, dma_rqst}, 16'd1);
        bus_write(O_NWORDS, 16'h0055);
        bus_write(O_START, 16'h1234);
        bus_write(O_CONFIG, 16'h000C);
        check("t5_nwords_lock", dma_num_words, 16'd2);
        check("t5_saddr_lock", dma_start_address, 16'h0200);
        check("t5_rdwr_lock", {15'd0, dma_rd_wr}, 16'd0);
        bus_read_check(O_NWORDS, 16'd2, "t5_nwords_rd");

        // 6. Asynchronous reset mid-burst
        bus_write(O_DATA, 16'hD001);
        bus_write(O_DATA, 16'hD002);
        bus_read_check(O_LEVEL, 16'd2, "t6_level2");
        check("t6_pre_ack", {15'd0, dev_ack}, 16'd1);
        check("t6_pre_irq", {15'd0, irq}, 16'd1);
        check("t6_pre_dev_out", dev_out, 16'hD001);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rqst", {15'd0, dma_rqst}, 16'd0);
        check("t6_ack",  {15'd0, dev_ack},  16'd0);
        check("t6_irq",  {15'd0, irq},      16'd0);
        check("t6_dev_out", dev_out, 16'h0000);
        check("t6_per_dout", per_dout, 16'h0000);
        per_addr = waddr(O_LEVEL);
        per_we = 2'b00;
        per_en = 1'b1;
        #1;
        check("t6_level0", per_dout, 16'h0000);
        per_addr = waddr(O_STATUS);
        #1;
        check("t6_status_rst", per_dout, 16'h0020);
        per_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        bus_read_check(O_CONFIG, 16'h0000, "t6_config_def");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
